// File: rtl/iterative_divider.sv
// Unsigned restoring divider with val/rdy streams: one quotient bit per cycle.
// Result {quotient, remainder} is held in DONE until the consumer takes it.
module iterative_divider #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*WIDTH-1:0]   istream_msg,
  input  logic                 istream_val,
  output logic                 istream_rdy,
  output logic [2*WIDTH-1:0]   ostream_msg,
  output logic                 ostream_val,
  input  logic                 ostream_rdy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   quo_r;
  logic [WIDTH-1:0]   dvs_r;
  logic [WIDTH-1:0]   rem_r;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH:0]     shifted_s;
  logic [WIDTH:0]     trial_s;

  // Trial subtraction for the current iteration; a set MSB means it borrowed.
  always_comb begin
    shifted_s = {rem_r, quo_r[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, dvs_r};
  end

  // Next-state logic of the control FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (istream_val) state_s = CALC;
        else             state_s = IDLE;
      end
      CALC: begin
        if (cnt_r == LAST_CNT) state_s = DONE;
        else                   state_s = CALC;
      end
      DONE: begin
        if (ostream_rdy) state_s = IDLE;
        else             state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Datapath: operand capture on accept, one restoring step per CALC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_r <= {WIDTH{1'b0}};
      dvs_r <= {WIDTH{1'b0}};
      rem_r <= {WIDTH{1'b0}};
      cnt_r <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (istream_val) begin
            quo_r <= istream_msg[2*WIDTH-1:WIDTH];
            dvs_r <= istream_msg[WIDTH-1:0];
            rem_r <= {WIDTH{1'b0}};
            cnt_r <= {CW{1'b0}};
          end
        end
        CALC: begin
          // A non-borrowing trial always fits in WIDTH bits since rem < divisor.
          if (!trial_s[WIDTH]) begin
            rem_r <= trial_s[WIDTH-1:0];
            quo_r <= {quo_r[WIDTH-2:0], 1'b1};
          end else begin
            rem_r <= shifted_s[WIDTH-1:0];
            quo_r <= {quo_r[WIDTH-2:0], 1'b0};
          end
          cnt_r <= cnt_r + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign istream_rdy = (state_r == IDLE);
  assign ostream_val = (state_r == DONE);
  assign ostream_msg = {quo_r, rem_r};

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: scoreboard of expected results
// pushed on input accept and popped on output handshake, plus directed checks.
module tb_iterative_divider;

  logic        clk;
  logic        rst;
  logic [63:0] istream_msg;
  logic        istream_val;
  logic        istream_rdy;
  logic [63:0] ostream_msg;
  logic        ostream_val;
  logic        ostream_rdy;

  int          n_cmp;
  int          n_err;
  int          cyc;
  int          n_acc;
  int          n_out;
  int          last_acc;
  int          acc_log[$];
  logic [63:0] exp_q[$];
  logic [63:0] out_log[$];

  iterative_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .istream_msg (istream_msg),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .ostream_msg (ostream_msg),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Reference division; a zero divisor yields all-ones quotient and the dividend as remainder.
  function automatic logic [63:0] model(input logic [63:0] m);
    logic [31:0] a;
    logic [31:0] b;
    a = m[63:32];
    b = m[31:0];
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    return {a / b, a % b};
  endfunction

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (istream_val && istream_rdy) begin
        exp_q.push_back(model(istream_msg));
        last_acc = cyc + 1;
        acc_log.push_back(cyc + 1);
        n_acc++;
      end
      if (ostream_val && ostream_rdy) begin
        n_out++;
        out_log.push_back(ostream_msg);
        if (exp_q.size() == 0) check("sb_unexpected_output", ostream_msg, 64'd0 - 64'd1);
        else                   check("scoreboard", ostream_msg, exp_q.pop_front());
      end
    end
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] b);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    istream_msg = {a, b};
    istream_val = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (istream_rdy) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    istream_val = 1'b0;
    istream_msg = {$urandom, $urandom};
  endtask

  task automatic wait_val(output int vcyc);
    bit got;
    got = 1'b0;
    vcyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ostream_val) begin
        got = 1'b1;
        vcyc = cyc;
        break;
      end
    end
    if (!got) check("val_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    int vc;
    do_op(a, b);
    wait_val(vc);
    check(tag, ostream_msg, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    int vc;
    int base_acc;
    int base_out;
    bit got;
    n_cmp = 0; n_err = 0; cyc = 0; n_acc = 0; n_out = 0; last_acc = 0;
    rst = 1'b1;
    istream_val = 1'b0;
    istream_msg = 64'd0;
    ostream_rdy = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset_val", {63'd0, ostream_val}, 64'd0);
    check("reset_msg", ostream_msg, 64'd0);
    rst = 1'b0;
    #1;
    check("reset_rdy", {63'd0, istream_rdy}, 64'd1);

    // 100/7: latency and ready return
    do_op(32'd100, 32'd7);
    wait_val(vc);
    check("lat_100_7", 64'(vc - last_acc), 64'd32);
    check("res_100_7", ostream_msg, 64'h0000000E_00000002);
    check("rdy_low_done", {63'd0, istream_rdy}, 64'd0);
    @(negedge clk);
    check("rdy_back", {63'd0, istream_rdy}, 64'd1);
    check("val_drop", {63'd0, ostream_val}, 64'd0);

    run_op("max_div_1", 32'hFFFF_FFFF, 32'd1, 64'hFFFFFFFF_00000000);
    run_op("max_div_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h00000001_00000000);
    run_op("small_div_big", 32'd5, 32'd9, 64'h00000000_00000005);
    run_op("div_by_zero", 32'h0000_1234, 32'd0, 64'hFFFFFFFF_00001234);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = (i == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      run_op("random", ra, rb, model({ra, rb}));
    end

    // Backpressure: 1000/33 held for 10 cycles while a second request waits
    ostream_rdy = 1'b0;
    do_op(32'd1000, 32'd33);
    wait_val(vc);
    base_out = n_out;
    @(posedge clk); #1;
    istream_msg = {32'd7, 32'd7};
    istream_val = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_msg", ostream_msg, 64'h0000001E_0000000A);
      check("bp_rdy", {63'd0, istream_rdy}, 64'd0);
      check("bp_val", {63'd0, ostream_val}, 64'd1);
    end
    @(posedge clk); #1;
    istream_val = 1'b0;
    ostream_rdy = 1'b1;
    @(posedge clk); #1;
    check("bp_idle", {63'd0, istream_rdy}, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bp_one_hs", 64'(n_out - base_out), 64'd1);

    // Asynchronous reset 10 cycles into 50/5
    do_op(32'd50, 32'd5);
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_val", {63'd0, ostream_val}, 64'd0);
    check("arst_msg", ostream_msg, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("arst_rdy", {63'd0, istream_rdy}, 64'd1);
    run_op("after_reset", 32'd77, 32'd8, 64'h00000009_00000005);

    // Back-to-back with valid and ready held high
    base_acc = n_acc;
    base_out = n_out;
    @(posedge clk); #1;
    istream_msg = {32'd20, 32'd3};
    istream_val = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (n_acc == base_acc + 1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("b2b_acc1_timeout", 64'd0, 64'd1);
    istream_msg = {32'd21, 32'd4};
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (n_acc == base_acc + 2) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("b2b_acc2_timeout", 64'd0, 64'd1);
    istream_val = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (n_out == base_out + 2) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("b2b_out_timeout", 64'd0, 64'd1);
    if (got && acc_log.size() >= 2 && out_log.size() >= 2) begin
      check("b2b_spacing", 64'(acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2]), 64'd34);
      check("b2b_res1", out_log[out_log.size()-2], 64'h00000006_00000002);
      check("b2b_res2", out_log[out_log.size()-1], 64'h00000005_00000001);
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iterative_divider.md
Name: iterative_divider

Overview:
- Unsigned restoring divider; the inverse of the iterative multiplier. Produces one quotient bit per cycle.
- Accepts {dividend, divisor} on a val/rdy input stream and returns {quotient, remainder} on a val/rdy output stream.
- Control FSM and datapath are in one module, and it drops into the same stream fabric as the multiplier.

Parameters:
- WIDTH, 32, operand width in bits. Must be at least 2. Counter width is clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- istream_msg  input  2*WIDTH  [2W-1:W] = dividend, [W-1:0] = divisor
- istream_val  input  1  input message valid
- istream_rdy  output  1  block can accept an input message
- ostream_msg  output  2*WIDTH  [2W-1:W] = quotient, [W-1:0] = remainder
- ostream_val  output  1  result valid
- ostream_rdy  input  1  consumer accepts the result

Behaviour:
- Reset:
  - rst high asynchronously forces state IDLE and clears all internal registers and the counter.
  - While rst is high: ostream_val=0 and ostream_msg=0.
  - istream_rdy=1 from the first cycle in IDLE.
- States: IDLE, CALC, DONE.
  - istream_rdy = (state==IDLE).
  - ostream_val = (state==DONE).
- Transitions:
  - IDLE -> CALC on istream_val & istream_rdy at a clock edge.
    - Latch quo_reg <= dividend, dvs_reg <= divisor, rem_reg <= 0, cnt <= 0.
  - CALC: one iteration per edge. Leave CALC when cnt==WIDTH-1 on that edge, after WIDTH iterations in total; next state DONE.
  - DONE -> IDLE on ostream_rdy. Otherwise hold in DONE.
  - No input is accepted in DONE. Throughput is one op per WIDTH+2 cycles when ostream_rdy is held high.
- Iteration (per CALC edge):
  - shifted = {rem_reg[W-1:0], quo_reg[W-1]}, W+1 bits.
  - trial = shifted - {1'b0, dvs_reg}, W+1 bits.
  - If trial[W]==0: rem_reg <= trial and quo_reg <= {quo_reg[W-2:0], 1}.
  - Else: rem_reg <= shifted and quo_reg <= {quo_reg[W-2:0], 0}.
  - cnt <= cnt+1.
- Latency: handshake accepted at edge E0 gives ostream_val=1 in the cycle following edge E_WIDTH, i.e. WIDTH cycles after acceptance.
- Output:
  - ostream_msg = {quo_reg, rem_reg[W-1:0]}.
  - Must be stable and unchanged for every cycle ostream_val=1 until the output handshake.
  - Outside DONE the value is don't-care, except 0 during reset.
- Divide by zero is not a special case in the datapath. The algorithm yields quotient = all ones and remainder = dividend; this result is required.
- Dividend < divisor: quotient 0, remainder = dividend.
- istream_val high while not in IDLE is ignored. The message is not consumed, since istream_rdy=0.
- Reset mid-CALC or mid-DONE:
  - The operation is discarded and no output is produced.
  - The next accepted op computes correctly with no residue from the aborted op.
- istream_msg is sampled only on the accepting edge. Changes afterwards have no effect.

Test Plan:
- 100/7 (msg 0x00000064_00000007), ostream_rdy=1:
  - ostream_val rises exactly 32 cycles after the accept edge with ostream_msg=0x0000000E_00000002.
  - istream_rdy returns to 1 one cycle later.
- 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0x00000000.
- 0xFFFFFFFF/0xFFFFFFFF -> quotient 0x00000001, remainder 0x00000000.
- 5/9 -> quotient 0x00000000, remainder 0x00000005.
- 0x00001234/0 -> quotient 0xFFFFFFFF, remainder 0x00001234.
- Backpressure: 1000/33 with ostream_rdy=0 for 10 cycles after ostream_val rises.
  - ostream_msg holds 0x0000001E_0000000A throughout.
  - istream_rdy stays 0 and a second istream_val is not consumed.
  - After ostream_rdy=1: one handshake occurs, then IDLE.
- Reset mid-operation: assert rst asynchronously (between edges) 10 cycles into 50/5.
  - Immediately: ostream_val=0 and ostream_msg=0.
  - After release: istream_rdy=1.
  - A subsequent 77/8 returns 0x00000009_00000005.
- Back-to-back with istream_val and ostream_rdy held high, ops 20/3 then 21/4:
  - Results 0x00000006_00000002 then 0x00000005_00000001.
  - Accepts spaced exactly 34 cycles apart.
